// File: rtl/coffee_pkg.sv
// Shared coffee-maker definitions: coin values and the change_dispenser state encoding.
package coffee_pkg;

  localparam int COIN_ONE  = 1;
  localparam int COIN_FIVE = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIVE,
    S_ONE,
    S_GAP,
    S_FIN,
    S_ACK
  } disp_state_e;

  // Largest coin first; S_FIN once nothing is owed.
  function automatic disp_state_e next_coin(input int unsigned rem);
    if (rem >= int'(COIN_FIVE)) return S_FIVE;
    if (rem >= int'(COIN_ONE))  return S_ONE;
    return S_FIN;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/result and coin-actuator signals between the controller side and change_dispenser.
interface change_dispenser_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] credit;
  logic [WIDTH-1:0] price;
  logic             coin_ack;
  logic             coin_five;
  logic             coin_one;
  logic             busy;
  logic             done;
  logic             err_short;
  logic [WIDTH-1:0] change_out;

  modport master (
    output start, credit, price, coin_ack,
    input  coin_five, coin_one, busy, done, err_short, change_out
  );

  modport slave (
    input  start, credit, price, coin_ack,
    output coin_five, coin_one, busy, done, err_short, change_out
  );
endinterface

// File: rtl/gap_timer.sv
// Settle-time timer for coin-return style actuators: load, count down GAP cycles, flag the last one.
module gap_timer #(
  parameter int GAP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_expired
);
  localparam int CW = $clog2(GAP + 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_load)           r_cnt <= CW'(GAP);
    else if (r_cnt != '0)      r_cnt <= r_cnt - CW'(1);
  end

  // High during the final wait cycle, so a waiter leaves after exactly GAP cycles.
  assign o_expired = (r_cnt <= CW'(1));

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out credit-price as five-unit then one-unit coin pulses.
// Optional DISPENSE_ACK_EN: hold after each pulse until coin_ack, then run the settle gap.
module change_dispenser
  import coffee_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PULSE_GAP = 3
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  disp_state_e      r_state;
  disp_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_credit;
  logic [WIDTH-1:0] r_price;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_change;
  logic             r_err;
  logic [WIDTH-1:0] w_diff;
  logic             w_short;
  logic             w_timer_load;
  logic             w_timer_expired;
  logic             w_coin_five;
  logic             w_coin_one;
  logic             w_busy;
  logic             w_done;

  assign w_short = (r_credit < r_price);
  assign w_diff  = r_credit - r_price;

  gap_timer #(.GAP(PULSE_GAP)) u_gap_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_load    (w_timer_load),
    .o_expired (w_timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_coin_five  = 1'b0;
    w_coin_one   = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_timer_load = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_busy      = 1'b1;
        w_state_nxt = w_short ? S_FIN : next_coin(32'(w_diff));
      end
      S_FIVE, S_ONE: begin
        w_busy      = 1'b1;
        w_coin_five = (r_state == S_FIVE);
        w_coin_one  = (r_state == S_ONE);
`ifdef DISPENSE_ACK_EN
        w_state_nxt = S_ACK;
`else
        w_timer_load = 1'b1;
        w_state_nxt  = S_GAP;
`endif
      end
      // Only reachable with the acknowledge handshake enabled.
      S_ACK: begin
        w_busy = 1'b1;
        if (bus.coin_ack) begin
          w_timer_load = 1'b1;
          w_state_nxt  = S_GAP;
        end
      end
      S_GAP: begin
        w_busy = 1'b1;
        if (w_timer_expired) w_state_nxt = next_coin(32'(r_rem));
      end
      S_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit <= '0;
      r_price  <= '0;
      r_rem    <= '0;
      r_change <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          r_credit <= bus.credit;
          r_price  <= bus.price;
          r_change <= '0;
          r_err    <= 1'b0;
        end
        S_LOAD: begin
          if (w_short) begin
            r_err <= 1'b1;
            r_rem <= '0;
          end else begin
            r_rem    <= w_diff;
            r_change <= w_diff;
          end
        end
        S_FIVE:  r_rem <= r_rem - WIDTH'(COIN_FIVE);
        S_ONE:   r_rem <= r_rem - WIDTH'(COIN_ONE);
        default: ;
      endcase
    end
  end

  assign bus.coin_five  = w_coin_five;
  assign bus.coin_one   = w_coin_one;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err_short  = r_err;
  assign bus.change_out = r_change;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, reset abort, randomized runs vs a payout model.
module tb_change_dispenser;

  localparam int WIDTH     = 4;
  localparam int PULSE_GAP = 3;
`ifdef DISPENSE_ACK_EN
  localparam int ACK_D = 5;
`else
  localparam int ACK_D = 0;
`endif
  localparam int PERIOD = 1 + ACK_D + PULSE_GAP;

  typedef struct {
    int    credit;
    int    price;
    int    exp_change;
    int    exp_err;
    int    exp_fives;
    int    exp_ones;
    int    exp_done;
    int    repulse;
    string name;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  change_dispenser_if #(.WIDTH(WIDTH)) bus ();

  change_dispenser #(.WIDTH(WIDTH), .PULSE_GAP(PULSE_GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payout rule: shortfall refunds nothing; otherwise greedy fives then ones.
  function automatic vec_t model(input int c, input int p, input string name);
    vec_t v;
    v.credit  = c;
    v.price   = p;
    v.name    = name;
    v.repulse = -1;
    if (c < p) begin
      v.exp_change = 0; v.exp_err = 1; v.exp_fives = 0; v.exp_ones = 0;
    end else begin
      v.exp_change = c - p; v.exp_err = 0;
      v.exp_fives  = (c - p) / 5;
      v.exp_ones   = (c - p) % 5;
    end
    v.exp_done = 2 + (v.exp_fives + v.exp_ones) * PERIOD;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int done_c;
    int seen_done;
    int nf;
    int no;
    done_c    = (ACK_D == 0) ? v.exp_done : 2 + (v.exp_fives + v.exp_ones) * PERIOD;
    seen_done = -1;
    nf        = 0;
    no        = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.credit = WIDTH'(v.credit);
    bus.price  = WIDTH'(v.price);
    for (int k = 1; k <= done_c + 1; k++) begin
      logic coin_now;
      logic e5;
      logic e1;
      @(negedge clk);
      coin_now = (k >= 2) && (k < done_c) && (((k - 2) % PERIOD) == 0);
      e5 = coin_now && (((k - 2) / PERIOD) < v.exp_fives);
      e1 = coin_now && !e5;
      check($sformatf("%s cyc%0d five/one/busy/done", v.name, k),
            {28'd0, bus.coin_five, bus.coin_one, bus.busy, bus.done},
            {28'd0, e5, e1, (k < done_c), (k == done_c)});
      if (k == 1) begin
        check($sformatf("%s err cleared on start", v.name), 32'(bus.err_short), 32'd0);
        check($sformatf("%s change cleared on start", v.name), 32'(bus.change_out), 32'd0);
      end
      if (bus.coin_five) nf++;
      if (bus.coin_one) no++;
      if (bus.done && seen_done < 0) seen_done = k;
      bus.start = (k == v.repulse);
      if (k == v.repulse) begin
        bus.credit = WIDTH'($urandom_range(0, 15));
        bus.price  = WIDTH'($urandom_range(0, 15));
      end
      bus.coin_ack = (ACK_D > 0) && (k >= 3) && (k < done_c) && (((k - 2) % PERIOD) == ACK_D);
    end
    bus.start    = 1'b0;
    bus.coin_ack = 1'b0;
    check($sformatf("%s five count", v.name), 32'(nf), 32'(v.exp_fives));
    check($sformatf("%s one count", v.name), 32'(no), 32'(v.exp_ones));
    check($sformatf("%s done cycle", v.name), 32'(seen_done), 32'(done_c));
    check($sformatf("%s change_out", v.name), 32'(bus.change_out), 32'(v.exp_change));
    check($sformatf("%s err_short", v.name), 32'(bus.err_short), 32'(v.exp_err));
  endtask

  initial begin
    vec_t table_v[$];
    vec_t v;
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.credit   = '0;
    bus.price    = '0;
    bus.coin_ack = 1'b0;

    table_v.push_back('{12,  5,  7, 0, 1, 0 + 2, 14, -1, "c12p5"});
    table_v.push_back('{ 3,  5,  0, 1, 0, 0,      2, -1, "c3p5"});
    table_v.push_back('{15,  0, 15, 0, 3, 0,     14, -1, "c15p0"});
    table_v.push_back('{ 6,  6,  0, 0, 0, 0,      2, -1, "c6p6"});
    table_v.push_back('{12,  5,  7, 0, 1, 2,     14,  5, "c12p5_restart"});
    table_v.push_back('{14,  0, 14, 0, 2, 4,     26, -1, "c14p0"});
    table_v.push_back('{ 7,  1,  6, 0, 1, 1,     10, -1, "c7p1"});
    table_v.push_back('{ 0, 15,  0, 1, 0, 0,      2, -1, "c0p15"});

    repeat (2) @(negedge clk);
    check("reset outputs", {26'd0, bus.coin_five, bus.coin_one, bus.busy, bus.done,
                            bus.err_short, 1'b0}, 32'd0);
    check("reset change_out", 32'(bus.change_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (table_v[i]) run_txn(table_v[i]);

    // Error flag must hold after the run until the next accepted start.
    repeat (3) @(negedge clk);
    check("err_short held idle", 32'(bus.err_short), 32'd1);

    // Reset between the first and second coin of a 12/5 run.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.credit = 4'd12;
    bus.price  = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort first pulse", 32'(bus.coin_five), 32'd1);
    repeat (2) @(negedge clk);
    check("abort change before reset", 32'(bus.change_out), 32'd7);
    reset = 1'b0;
    #1;
    check("abort outputs cleared", {26'd0, bus.coin_five, bus.coin_one, bus.busy, bus.done,
                                    bus.err_short, 1'b0}, 32'd0);
    check("abort change cleared", 32'(bus.change_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post-abort idle", {28'd0, bus.coin_five, bus.coin_one, bus.busy, bus.done}, 32'd0);
    run_txn(model(9, 3, "post_abort_c9p3"));

    for (int n = 0; n < 30; n++) begin
      v = model(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $sformatf("rand%0d", n));
      if (v.exp_done > 3 && ($urandom_range(0, 1) == 1))
        v.repulse = int'($urandom_range(1, v.exp_done - 1));
      run_txn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
